fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
LC-3b instruction fetch stage, directly upstream of decode. It owns the PC and runs the single-outstanding read handshake to instruction memory. It delivers one 16-bit instruction per accepted transfer to decode through a registered IF/ID buffer with a valid/ready handshake. It also accepts PC redirects from later stages and discards any in-flight fetch they make stale.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset; bit 0 must be 0.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_read  output  1  instruction memory read request
imem_address  output  16  byte address of request; equals fetch_pc
imem_rdata  input  16  instruction word, valid when imem_resp=1
imem_resp  input  1  memory response; one-cycle pulse ending the request
id_ready  input  1  decode accepts the buffer this cycle
redirect  input  1  one-cycle PC redirect (taken branch/JMP/JSR/TRAP)
redirect_pc  input  16  redirect target; bit 0 ignored and forced to 0
out_valid  output  1  IF/ID buffer holds a valid instruction
instruction  output  16  IF/ID instruction, to decode
pc_out  output  16  address of the buffered instruction
pc_plus2  output  16  pc_out + 2, mod 2^16

Behaviour:
- Reset (async, rst_n=0) sets:
  - fetch_pc=PC_RESET, busy=0, squash=0, out_valid=0.
  - instruction, pc_out and pc_plus2 = 16'h0000.
  - imem_read=0 immediately; any in-flight request is abandoned.
- State: busy flag, squash flag, fetch_pc register, IF/ID buffer.
  - IDLE: busy=0. REQ: busy=1. SQUASH: busy=1 and squash=1.
- drain = out_valid & id_ready.
- start = !busy & (!out_valid | id_ready) & !redirect.
- imem_read = busy | start (combinational). imem_address = fetch_pc, held stable while imem_read=1.
- IDLE to REQ when start=1. A response may arrive in the same cycle as start, giving zero-bubble back-to-back fetch when id_ready stays high.
- REQ with imem_resp=1 and no redirect:
  - Buffer <= {imem_rdata, fetch_pc, fetch_pc+2}, out_valid <= 1.
  - fetch_pc <= fetch_pc+2, busy <= 0.
  - The load never overwrites undrained data: a request starts only when the buffer is empty or draining, and only responses fill it.
- drain without a buffer load in the same cycle: out_valid <= 0.
- A drain and a load in the same cycle: the load wins and out_valid stays 1.
- Redirect (priority over all other updates):
  - out_valid <= 0; the buffer is flushed, and downstream discards anything it accepted in the redirect cycle.
  - IDLE: fetch_pc <= {redirect_pc[15:1],0}. No request that cycle; start is evaluated next cycle.
  - REQ without imem_resp: imem_read stays asserted at the old address until imem_resp. Set squash=1 and fetch_pc is not updated yet. Latch the target in pending_pc.
  - REQ with imem_resp in the same cycle: the response is discarded, fetch_pc <= target, busy <= 0.
  - SQUASH with a second redirect: pending_pc is overwritten; the latest redirect wins.
- SQUASH with imem_resp: data is discarded, fetch_pc <= pending_pc, busy <= 0, squash <= 0, out_valid unchanged (0).
- PC wrap: 16'hFFFE + 2 = 16'h0000 for both fetch_pc and pc_plus2.
- Outputs instruction, pc_out and pc_plus2 change only on a buffer load or reset. Their value while out_valid=0 is don't-care.
- Latency: with no stall and same-cycle memory response, out_valid rises 1 cycle after start.

Test Plan:
- Reset then zero-wait memory, id_ready=1 -> imem_address 0000, 0002, 0004 on consecutive cycles; out_valid continuous; pc_plus2 = pc_out + 2.
- id_ready=0 after first instruction (rdata 16'h1234 at 0000) -> buffer holds 1234/0000; imem_read=0 after that response; raising id_ready restarts the fetch at 0002 in that cycle.
- 3-cycle memory latency with redirect to 16'h3001 in wait cycle 1 -> address 0000 held until resp; data discarded, out_valid stays 0; next imem_address 16'h3000.
- Redirect coincident with imem_resp while buffer valid -> out_valid 0 next cycle; next request at target; the response word never appears on instruction.
- Two redirects (0x4000 then 0x5000) during one outstanding request -> next fetch address 0x5000.
- PC_RESET=16'hFFFE -> first output pc_out FFFE, pc_plus2 0000; next imem_address 0000.
- rst_n pulled low mid-request -> imem_read and out_valid drop immediately; after release, fetch restarts at PC_RESET.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: LC-3b instruction fetch stage, directly upstream of decode.
//
// Owns the fetch PC and keeps at most one read outstanding to instruction
// memory. Each accepted response is captured into a registered IF/ID buffer
// that decode takes with a valid/ready handshake. PC redirects from later
// stages flush the buffer and steer the next fetch; a redirect that lands
// while a read is outstanding leaves that read running until its response
// arrives, and the returned word is then thrown away.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   imem_read           read request, combinational (busy | start)
//   imem_address        byte address of the request (the fetch PC)
//   imem_rdata          instruction word, valid with imem_resp
//   imem_resp           one-cycle pulse that ends the outstanding request
//   id_ready            decode takes the IF/ID buffer this cycle
//   redirect            one-cycle PC redirect
//   redirect_pc         redirect target, bit 0 forced to 0
//   out_valid           IF/ID buffer holds a valid instruction
//   instruction         buffered instruction word
//   pc_out              address of the buffered instruction
//   pc_plus2            pc_out + 2, wrapping at 16 bits
module fetch_stage #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  output logic [15:0] instruction,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2
);

  // IDLE: no read outstanding. REQ: read outstanding, result wanted.
  // SQUASH: read outstanding, result stale; pending_pc holds the next PC.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SQUASH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] pending_pc_q, pending_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;

  logic        busy;
  logic        drain;
  logic        start;
  logic        load;
  logic [15:0] target;
  logic [15:0] fetch_pc_inc;

  assign busy         = (state_q != IDLE);
  assign drain        = out_valid_q & id_ready;
  // Gating with rst_n keeps imem_read low for the whole time reset is held,
  // even though the reset state would otherwise look ready to start.
  assign start        = rst_n & ~busy & (~out_valid_q | id_ready) & ~redirect;
  assign target       = {redirect_pc[15:1], 1'b0};
  assign fetch_pc_inc = fetch_pc_q + 16'd2;
  // A response fills the buffer only for a live (non-squashed) request; that
  // request is either already outstanding or starting this very cycle.
  assign load         = imem_resp & ~redirect & ((state_q == REQ) | start);

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    out_valid_d  = out_valid_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    pc_plus2_d   = pc_plus2_q;

    if (redirect) begin
      // Redirect outranks everything, including a response in the same cycle.
      out_valid_d = 1'b0;
      case (state_q)
        REQ, SQUASH: begin
          if (imem_resp) begin
            fetch_pc_d = target;
            state_d    = IDLE;
          end else begin
            // Address must stay stable until the response, so park the target.
            pending_pc_d = target;
            state_d      = SQUASH;
          end
        end
        default: begin
          fetch_pc_d = target;
          state_d    = IDLE;
        end
      endcase
    end else begin
      if (drain) begin
        out_valid_d = 1'b0;
      end
      if (load) begin
        out_valid_d = 1'b1;
        instr_d     = imem_rdata;
        pc_out_d    = fetch_pc_q;
        pc_plus2_d  = fetch_pc_inc;
        fetch_pc_d  = fetch_pc_inc;
        state_d     = IDLE;
      end else if (start) begin
        state_d = REQ;
      end else if ((state_q == SQUASH) && imem_resp) begin
        fetch_pc_d = pending_pc_q;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_pc_q   <= PC_RESET;
      pending_pc_q <= 16'h0000;
      out_valid_q  <= 1'b0;
      instr_q      <= 16'h0000;
      pc_out_q     <= 16'h0000;
      pc_plus2_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      out_valid_q  <= out_valid_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      pc_plus2_q   <= pc_plus2_d;
    end
  end

  assign imem_read    = busy | start;
  assign imem_address = fetch_pc_q;
  assign out_valid    = out_valid_q;
  assign instruction  = instr_q;
  assign pc_out       = pc_out_q;
  assign pc_plus2     = pc_plus2_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage.
//
// dut drives a bench memory with a programmable response latency; every
// instruction that should reach decode is queued when its fetch is issued and
// checked when decode takes it. dut2 uses PC_RESET=16'hFFFE with a manually
// driven memory to cover the reset-PC wrap.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;

  logic        imem_read2;
  logic [15:0] imem_address2;
  logic [15:0] imem_rdata2;
  logic        imem_resp2;
  logic        id_ready2;
  logic        redirect2;
  logic [15:0] redirect_pc2;
  logic        out_valid2;
  logic [15:0] instruction2;
  logic [15:0] pc_out2;
  logic [15:0] pc_plus2_2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } sb_t;
  sb_t exp_q[$];

  fetch_stage #(.PC_RESET(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_address(imem_address),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .instruction(instruction),
    .pc_out(pc_out), .pc_plus2(pc_plus2)
  );

  fetch_stage #(.PC_RESET(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read2), .imem_address(imem_address2),
    .imem_rdata(imem_rdata2), .imem_resp(imem_resp2),
    .id_ready(id_ready2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .instruction(instruction2),
    .pc_out(pc_out2), .pc_plus2(pc_plus2_2)
  );

  // Memory contents: a fixed scramble of the address so each word is distinct.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Bench memory for dut: answers a request in its lat-th cycle of imem_read
  // (lat=1 answers in the same cycle). Evaluated 2 time units after each
  // rising edge, once the DUT's combinational request has settled.
  int          lat = 1;
  int          wait_cnt = 0;
  logic        auto_resp = 1'b0;
  logic [15:0] auto_rdata = 16'h0000;
  assign imem_resp  = auto_resp;
  assign imem_rdata = auto_rdata;

  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      auto_resp = 1'b0;
      wait_cnt  = 0;
    end else if (imem_read) begin
      if (wait_cnt + 1 >= lat) begin
        auto_resp  = 1'b1;
        auto_rdata = memWord(imem_address);
        wait_cnt   = 0;
      end else begin
        auto_resp = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      auto_resp = 1'b0;
      wait_cnt  = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input logic [15:0] pc);
    sb_t e;
    e.instr = memWord(pc);
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // One cycle: drive inputs just after the rising edge, then on the falling
  // edge compare whatever decode takes this cycle against the scoreboard.
  task automatic applyStimulus(input logic rd, input logic [15:0] rpc, input logic rdy);
    sb_t e;
    @(posedge clk);
    #1;
    redirect    = rd;
    redirect_pc = rpc;
    id_ready    = rdy;
    @(negedge clk);
    if (rst_n && out_valid && id_ready && !redirect) begin
      checkOutput("sb_nonempty", {15'd0, exp_q.size() != 0}, 16'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("sb_instr", instruction, e.instr);
        checkOutput("sb_pc_out", pc_out, e.pc);
        checkOutput("sb_pc_plus2", pc_plus2, e.pc + 16'd2);
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    id_ready     = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 16'h0000;
    id_ready2    = 1'b0;
    redirect2    = 1'b0;
    redirect_pc2 = 16'h0000;
    imem_resp2   = 1'b0;
    imem_rdata2  = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_imem_read", imem_read, 16'd0);
    checkOutput("rst_out_valid", out_valid, 16'd0);
    checkOutput("rst_instruction", instruction, 16'h0000);
    checkOutput("rst_pc_out", pc_out, 16'h0000);
    checkOutput("rst_pc_plus2", pc_plus2, 16'h0000);
    checkOutput("rst_addr", imem_address, 16'h0000);
    checkOutput("rst2_imem_read", imem_read2, 16'd0);
    checkOutput("rst2_out_valid", out_valid2, 16'd0);
    rst_n = 1'b1;

    $display("[TB] zero-wait back-to-back fetch");
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t1_read_0", imem_read, 16'd1);
    checkOutput("t1_addr_0", imem_address, 16'h0000);
    pushExp(16'h0000);
    checkOutput("t6_read", imem_read2, 16'd1);
    checkOutput("t6_addr_first", imem_address2, 16'hFFFE);
    imem_resp2  = 1'b1;
    imem_rdata2 = memWord(16'hFFFE);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t1_valid_2", out_valid, 16'd1);
    checkOutput("t1_addr_2", imem_address, 16'h0002);
    pushExp(16'h0002);
    imem_resp2 = 1'b0;
    checkOutput("t6_valid", out_valid2, 16'd1);
    checkOutput("t6_instr", instruction2, memWord(16'hFFFE));
    checkOutput("t6_pc_out", pc_out2, 16'hFFFE);
    checkOutput("t6_pc_plus2_wrap", pc_plus2_2, 16'h0000);
    checkOutput("t6_next_addr_wrap", imem_address2, 16'h0000);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t1_valid_4", out_valid, 16'd1);
    checkOutput("t1_addr_4", imem_address, 16'h0004);
    pushExp(16'h0004);

    $display("[TB] decode stall");
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t2_read_stalled", imem_read, 16'd0);
    checkOutput("t2_hold_instr", instruction, memWord(16'h0004));
    checkOutput("t2_hold_pc", pc_out, 16'h0004);
    checkOutput("t2_hold_pc_plus2", pc_plus2, 16'h0006);

    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t2_read_stalled_2", imem_read, 16'd0);
    checkOutput("t2_valid_held", out_valid, 16'd1);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t2_restart_read", imem_read, 16'd1);
    checkOutput("t2_restart_addr", imem_address, 16'h0006);
    pushExp(16'h0006);
    lat = 3;

    $display("[TB] redirect during a 3-cycle read");
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t3_read_start", imem_read, 16'd1);
    checkOutput("t3_addr_start", imem_address, 16'h0008);

    applyStimulus(1'b1, 16'h3001, 1'b0);
    checkOutput("t3_read_w1", imem_read, 16'd1);
    checkOutput("t3_addr_w1", imem_address, 16'h0008);

    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t3_read_resp", imem_read, 16'd1);
    checkOutput("t3_addr_resp", imem_address, 16'h0008);
    checkOutput("t3_valid_resp", out_valid, 16'd0);

    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t3_valid_after", out_valid, 16'd0);
    checkOutput("t3_read_target", imem_read, 16'd1);
    checkOutput("t3_addr_target", imem_address, 16'h3000);
    pushExp(16'h3000);
    lat = 1;

    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t3_addr_target_held", imem_address, 16'h3000);
    checkOutput("t3_valid_wait", out_valid, 16'd0);
    lat = 2;

    $display("[TB] redirect coincident with response");
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t4_valid_before", out_valid, 16'd1);
    checkOutput("t4_addr_req", imem_address, 16'h3002);

    applyStimulus(1'b1, 16'h4444, 1'b1);
    checkOutput("t4_read_resp", imem_read, 16'd1);
    checkOutput("t4_addr_resp", imem_address, 16'h3002);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t4_valid_after", out_valid, 16'd0);
    checkOutput("t4_addr_target", imem_address, 16'h4444);
    checkOutput("t4_instr_not_loaded", instruction, memWord(16'h3000));
    lat = 4;

    $display("[TB] two redirects in one outstanding read");
    applyStimulus(1'b1, 16'h4000, 1'b1);
    checkOutput("t5_addr_r1", imem_address, 16'h4444);

    applyStimulus(1'b1, 16'h5000, 1'b1);
    checkOutput("t5_addr_r2", imem_address, 16'h4444);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t5_read_resp", imem_read, 16'd1);
    checkOutput("t5_addr_resp", imem_address, 16'h4444);
    checkOutput("t5_valid_resp", out_valid, 16'd0);
    lat = 1;

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t5_valid_after", out_valid, 16'd0);
    checkOutput("t5_addr_latest", imem_address, 16'h5000);
    pushExp(16'h5000);
    lat = 3;

    $display("[TB] reset mid-request");
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t7_valid_before", out_valid, 16'd1);
    checkOutput("t7_read_before", imem_read, 16'd1);
    checkOutput("t7_addr_before", imem_address, 16'h5002);
    checkOutput("t7_valid2_before", out_valid2, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t7_read_drop", imem_read, 16'd0);
    checkOutput("t7_valid_drop", out_valid, 16'd0);
    checkOutput("t7_valid2_drop", out_valid2, 16'd0);
    checkOutput("t7_addr_reset", imem_address, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t7_read_held", imem_read, 16'd0);
    checkOutput("t7_pc_out_reset", pc_out, 16'h0000);
    lat = 1;
    rst_n = 1'b1;

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t7_restart_read", imem_read, 16'd1);
    checkOutput("t7_restart_addr", imem_address, 16'h0000);
    pushExp(16'h0000);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t7_valid_0", out_valid, 16'd1);
    checkOutput("t7_addr_2", imem_address, 16'h0002);
    pushExp(16'h0002);

    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("t7_valid_2", out_valid, 16'd1);
    checkOutput("t7_addr_4", imem_address, 16'h0004);

    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("t7_valid_4", out_valid, 16'd1);
    checkOutput("t7_pc_out_4", pc_out, 16'h0004);
    checkOutput("t7_read_stall", imem_read, 16'd0);

    checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
